// File: rtl/led_pwm_driver.sv
// led_pwm_driver
//   Output stage between the SoC's LED word and the 8 board LED pins.
//   The word is decoded into an on/off pattern, a global PWM brightness and
//   an optional blink. A new word is adopted only at a PWM period boundary,
//   so the pins never show a partially updated configuration.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset (all state to zero)
//   led_in        SoC LED word: [7:0] pattern, [11:8] brightness,
//                 [12] blink enable, [15:13] blink rate, upper bits ignored
//   led_out       registered LED pin drive
//   period_start  one-cycle pulse on the cycle after each PWM period boundary
module led_pwm_driver #(
  parameter int WIDTH_D   = 32,
  parameter int PRESCALE  = 64,
  parameter int PWM_BITS  = 4,
  parameter int BLINK_MIN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH_D-1:0] led_in,
  output logic [7:0]         led_out,
  output logic               period_start
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam int BLK_W = BLINK_MIN + 8;
  // Brightness and PWM count are compared at the wider of the two widths.
  localparam int CMP_W = (PWM_BITS > 4) ? PWM_BITS : 4;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [15:0]         led_q,          led_d;
  logic [PRE_W-1:0]    pre_cnt_q,      pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,      pwm_cnt_d;
  logic [15:0]         cfg_q,          cfg_d;
  logic [BLK_W-1:0]    blink_cnt_q,    blink_cnt_d;
  logic                period_start_q, period_start_d;
  logic [7:0]          led_out_q,      led_out_d;

  logic                tick_s;
  logic                bnd_s;
  logic                pwm_on_s;
  logic                blink_vis_s;
  logic [BLK_W-1:0]    blink_shift_s;

  // Bits above the decoded field carry no meaning for the LEDs.
  if (WIDTH_D > 16) begin : g_hi_bits
    logic hi_unused_s;
    assign hi_unused_s = ^led_in[WIDTH_D-1:16];
  end

  // Prescaler tick, period boundary, duty and blink visibility.
  always_comb begin
    tick_s        = (pre_cnt_q == PRE_LAST);
    bnd_s         = tick_s && (pwm_cnt_q == {PWM_BITS{1'b1}});
    pwm_on_s      = (CMP_W'(pwm_cnt_q) <= CMP_W'(cfg_q[11:8]));
    // Blink phase bit is BLINK_MIN+rate; shifting it down to bit 0 avoids
    // a variable part-select.
    blink_shift_s = blink_cnt_q >> (BLINK_MIN + int'(cfg_q[15:13]));
    if (cfg_q[12]) begin
      blink_vis_s = ~blink_shift_s[0];
    end else begin
      blink_vis_s = 1'b1;
    end
  end

  // Next-state logic for counters, active configuration and outputs.
  always_comb begin
    led_d          = led_in[15:0];
    pre_cnt_d      = pre_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    cfg_d          = cfg_q;
    blink_cnt_d    = blink_cnt_q;
    period_start_d = 1'b0;

    if (tick_s) begin
      pre_cnt_d = {PRE_W{1'b0}};
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1'b1);
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1'b1);
      pwm_cnt_d = pwm_cnt_q;
    end

    if (bnd_s) begin
      // Config comes from the registered word, so a led_in change on the
      // boundary cycle itself waits for the following boundary.
      cfg_d          = led_q;
      period_start_d = 1'b1;
      // A fresh enable restarts the blink so it always opens with an on-phase.
      if (led_q[12] && !cfg_q[12]) begin
        blink_cnt_d = {BLK_W{1'b0}};
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1'b1);
      end
    end else begin
      cfg_d          = cfg_q;
      blink_cnt_d    = blink_cnt_q;
      period_start_d = 1'b0;
    end

    led_out_d = cfg_q[7:0] & {8{pwm_on_s & blink_vis_s}};
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q          <= {16{1'b0}};
      pre_cnt_q      <= {PRE_W{1'b0}};
      pwm_cnt_q      <= {PWM_BITS{1'b0}};
      cfg_q          <= {16{1'b0}};
      blink_cnt_q    <= {BLK_W{1'b0}};
      period_start_q <= 1'b0;
      led_out_q      <= {8{1'b0}};
    end else begin
      led_q          <= led_d;
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      cfg_q          <= cfg_d;
      blink_cnt_q    <= blink_cnt_d;
      period_start_q <= period_start_d;
      led_out_q      <= led_out_d;
    end
  end

  assign led_out      = led_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver
//   Bench for led_pwm_driver with PRESCALE=4, PWM_BITS=4, BLINK_MIN=1
//   (64 clk per PWM period). A time-based model predicts led_out and
//   period_start for every cycle; directed sequences add literal checks.
module tb_led_pwm_driver;

  localparam int WIDTH_D   = 32;
  localparam int PRESCALE  = 4;
  localparam int PWM_BITS  = 4;
  localparam int BLINK_MIN = 1;
  localparam int PERIOD    = PRESCALE * (1 << PWM_BITS);
  localparam int BLK_MOD   = 1 << (BLINK_MIN + 8);

  logic               clk;
  logic               reset;
  logic [WIDTH_D-1:0] led_in;
  logic [7:0]         led_out;
  logic               period_start;

  int vectors;
  int miscompares;

  led_pwm_driver #(
    .WIDTH_D  (WIDTH_D),
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS),
    .BLINK_MIN(BLINK_MIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .led_in      (led_in),
    .led_out     (led_out),
    .period_start(period_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position inside the period follows from edges since reset release;
  // blink phase follows from periods elapsed since the enable was switched on.
  initial begin : model_cmp
    int          m_n;
    int          m_k;
    logic [15:0] m_lq;
    logic [15:0] m_cfg;
    logic [7:0]  e_out;
    logic        e_ps;
    bit          e_valid;
    int          pwm;
    bit          on;
    bit          vis;
    m_n = 0; m_k = 0; m_lq = 16'h0000; m_cfg = 16'h0000;
    e_out = 8'h00; e_ps = 1'b0; e_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_led_out", {24'h0, led_out}, 32'h0);
        check("reset_period_start", {31'h0, period_start}, 32'h0);
        m_n = 0; m_k = 0; m_lq = 16'h0000; m_cfg = 16'h0000;
        e_out = 8'h00; e_ps = 1'b0; e_valid = 1'b1;
      end else begin
        if (e_valid) begin
          check("model_led_out", {24'h0, led_out}, {24'h0, e_out});
          check("model_period_start", {31'h0, period_start}, {31'h0, e_ps});
        end
        pwm = (m_n % PERIOD) / PRESCALE;
        on  = (pwm <= int'(m_cfg[11:8]));
        if (m_cfg[12])
          vis = (((m_k >> (BLINK_MIN + int'(m_cfg[15:13]))) & 1) == 0);
        else
          vis = 1'b1;
        e_out = (on && vis) ? m_cfg[7:0] : 8'h00;
        e_ps  = (((m_n + 1) % PERIOD) == 0);
        if (e_ps) begin
          if (m_lq[12] && !m_cfg[12]) m_k = 0;
          else                        m_k = (m_k + 1) % BLK_MOD;
          m_cfg = m_lq;
        end
        m_lq    = led_in[15:0];
        m_n     = m_n + 1;
        e_valid = 1'b1;
      end
    end
  end

  // Waits for the next period_start pulse, bounded.
  task automatic wait_ps();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    check("period_start_seen", {31'h0, found}, 32'h1);
  endtask

  // Counts edges from reset release to the first period_start.
  task automatic measure_first_ps();
    int cnt;
    cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #2;
      if (period_start) begin
        cnt = c;
        break;
      end
    end
    check("first_period_start_clk", cnt, 64);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    led_in      = 32'h0000FFFF;
    #2 reset = 1'b1;

    // Case 1: outputs dark while reset is held, first boundary 64 clk after release.
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_led_out", {24'h0, led_out}, 32'h0);
    check("in_reset_period_start", {31'h0, period_start}, 32'h0);
    #1 reset = 1'b0;
    measure_first_ps();

    // Case 2: full brightness, junk in the ignored upper bits.
    led_in = 32'hDEAD0FA5;
    wait_ps();
    for (int j = 1; j <= 64; j++) begin
      @(posedge clk); #2;
      check("bright15_led_out", {24'h0, led_out}, 32'hA5);
    end

    // Case 3: brightness 3 -> 16 clk on, 48 clk off.
    led_in = 32'h000003FF;
    wait_ps();
    for (int j = 1; j <= 64; j++) begin
      @(posedge clk); #2;
      check("bright3_led_out", {24'h0, led_out}, (j <= 16) ? 32'hFF : 32'h00);
    end

    // Case 4: mid-period change is held off until the next boundary.
    led_in = 32'h00000FA5;
    wait_ps();
    repeat (20) @(posedge clk);
    #2 led_in = 32'h00000F3C;
    for (int j = 21; j <= 65; j++) begin
      @(posedge clk); #2;
      check("midchange_led_out", {24'h0, led_out}, (j <= 64) ? 32'hA5 : 32'h3C);
      check("midchange_period_start", {31'h0, period_start}, (j == 64) ? 32'h1 : 32'h0);
    end

    // Case 5: blink rate 0 -> two periods on, two off, starting on.
    led_in = 32'h00001FFF;
    wait_ps();
    for (int j = 1; j <= 5 * 64; j++) begin
      @(posedge clk); #2;
      check("blink_led_out", {24'h0, led_out},
            ((((j - 1) / 64) % 4) < 2) ? 32'hFF : 32'h00);
    end

    // Case 6: asynchronous reset mid-period during an on-phase, then restart.
    repeat (37) @(posedge clk);
    #1;
    check("pre_abort_led_out", {24'h0, led_out}, 32'hFF);
    #2 reset = 1'b1;
    #1;
    check("async_reset_led_out", {24'h0, led_out}, 32'h0);
    check("async_reset_period_start", {31'h0, period_start}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b0;
    led_in = 32'h0000FFFF;
    measure_first_ps();
    repeat (4) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
